// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer: FSM state encoding and the even-parity bit.
package serializer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_e;

   // Inputs narrower than 32 bits are zero-extended, which leaves the XOR unchanged.
   function automatic logic parity_bit(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running completed-word counter; +1 per enabled cycle, wraps all-ones -> 0.
// Registered output, no backpressure.
module wrap_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc_en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_en) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial MSB-first shifter; first bit one cycle after acceptance, gapless back-to-back words.
// in_ready drops while shifting; SERIALIZER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer
   import serializer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic             dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic             cnt_inc;
   logic             last_bit;
   logic             accept;
`ifdef SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   // bitcnt_q counts payload bits still to be emitted after the one on dout.
   assign last_bit = (state_q == SHIFT) && (bitcnt_q == '0);

`ifdef SERIALIZER_PARITY_EN
   assign in_ready = (state_q == IDLE) || (state_q == PARITY);
`else
   assign in_ready = (state_q == IDLE) || last_bit;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bitcnt_d   = bitcnt_q;
      dout_d     = 1'b0;
      dout_vld_d = 1'b0;
      cnt_inc    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_d      = par_q;
`endif

      case (state_q)
         SHIFT: begin
            if (bitcnt_q != '0) begin
               dout_d     = shreg_q[WIDTH-1];
               dout_vld_d = 1'b1;
               shreg_d    = shreg_q << 1;
               bitcnt_d   = bitcnt_q - BW'(1);
`ifndef SERIALIZER_PARITY_EN
               cnt_inc    = (bitcnt_q == BW'(1));
`endif
            end else begin
`ifdef SERIALIZER_PARITY_EN
               state_d    = PARITY;
               dout_d     = par_q;
               dout_vld_d = 1'b1;
               cnt_inc    = 1'b1;
`else
               state_d    = IDLE;
`endif
            end
         end
`ifdef SERIALIZER_PARITY_EN
         PARITY: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase

      // Acceptance happens only when nothing else is emitting next cycle, so it may override.
      if (accept) begin
         state_d    = SHIFT;
         dout_d     = in_data[WIDTH-1];
         dout_vld_d = 1'b1;
         shreg_d    = in_data << 1;
         bitcnt_d   = LAST_IDX;
`ifdef SERIALIZER_PARITY_EN
         par_d      = parity_bit(32'(in_data));
`endif
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
         dout_q     <= 1'b0;
         dout_vld_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bitcnt_q   <= bitcnt_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
`ifdef SERIALIZER_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_vld_q;
   assign busy       = (state_q != IDLE);

   wrap_counter #(
      .CNT_W (CNT_W)
   ) u_word_cnt (
      .clk    (clk),
      .rstn   (rstn),
      .inc_en (cnt_inc),
      .count  (word_cnt)
   );

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default instance plus a CNT_W=2 instance sharing the stimulus.
module tb_bit_serializer;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready, dout, dout_valid, busy;
   logic [15:0] word_cnt;
   logic        in_ready2, dout2, dout_valid2, busy2;
   logic [1:0]  word_cnt2;

   int checks = 0;
   int errors = 0;

`ifdef SERIALIZER_PARITY_EN
   localparam int NB = 9;
   localparam logic [17:0] STREAM2 = {8'hB0, 1'b1, 8'h0B, 1'b1};
`else
   localparam int NB = 8;
   localparam logic [17:0] STREAM2 = {8'hB0, 8'h0B, 2'b00};
`endif

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
      .busy(busy), .word_cnt(word_cnt)
   );

   bit_serializer #(.WIDTH(8), .CNT_W(2)) dut_w2 (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready2), .dout(dout2), .dout_valid(dout_valid2),
      .busy(busy2), .word_cnt(word_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // Sends one word from IDLE and checks its bits (left-aligned in exp) and the idle cycle after.
   task automatic send(input string tag, input logic [7:0] data, input logic [8:0] exp);
      in_data  = data;
      in_valid = 1'b1;
      chk({tag, " in_ready"}, in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         chk({tag, " vld"}, dout_valid, 1'b1);
         chk({tag, " bit"}, dout, exp[8-i]);
         tick();
      end
      chk({tag, " vld_end"}, dout_valid, 1'b0);
      chk({tag, " dout_end"}, dout, 1'b0);
      chk({tag, " busy_end"}, busy, 1'b0);
   endtask

   initial begin
      logic [3:0] win;
      int         hits;
      logic [1:0] exp_w2 [5];
      exp_w2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset state
      rstn     = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #3;
      chk("rst dout", dout, 1'b0);
      chk("rst vld", dout_valid, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst cnt", word_cnt, 16'd0);
      tick();
      rstn = 1'b1;
      chk("idle ready", in_ready, 1'b1);

      // Single word 0xB6, counter increments with the final bit
      in_data  = 8'hB6;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("b6 cnt_first", word_cnt, 16'd0);
      chk("b6 busy", busy, 1'b1);
      chk("b6 ready_mid", in_ready, 1'b0);
      for (int i = 0; i < NB; i++) begin
         chk("b6 vld", dout_valid, 1'b1);
`ifdef SERIALIZER_PARITY_EN
         chk("b6 bit", dout, (i == 8) ? 1'b1 : 1'(8'hB6 >> (7 - i)));
`else
         chk("b6 bit", dout, 1'(8'hB6 >> (7 - i)));
`endif
         tick();
      end
      chk("b6 vld_end", dout_valid, 1'b0);
      chk("b6 dout_end", dout, 1'b0);
      chk("b6 cnt", word_cnt, 16'd1);

      // Back-to-back 0xB0 then 0x0B with in_valid held
      do_reset();
      in_data  = 8'hB0;
      in_valid = 1'b1;
      tick();
      in_data = 8'h0B;
      win  = 4'h0;
      hits = 0;
      for (int i = 0; i < 2 * NB; i++) begin
         if (i == NB) in_valid = 1'b0;
         if (i == 2) chk("b2b ready_mid", in_ready, 1'b0);
         if (i == NB - 1) chk("b2b ready_last", in_ready, 1'b1);
         chk("b2b vld", dout_valid, 1'b1);
         chk("b2b bit", dout, STREAM2[17-i]);
         win = {win[2:0], dout};
         if (i >= 3 && win == 4'b1011) hits++;
         tick();
      end
      chk("b2b vld_end", dout_valid, 1'b0);
      chk("b2b detect", hits, 2);
      chk("b2b cnt", word_cnt, 16'd2);

      // Valid pulsed mid-word is ignored
      do_reset();
      in_data  = 8'hB6;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (i == 3) begin
            in_data  = 8'hFF;
            in_valid = 1'b1;
            chk("busy ready", in_ready, 1'b0);
         end
         if (i == 4) in_valid = 1'b0;
         chk("busy vld", dout_valid, 1'b1);
`ifdef SERIALIZER_PARITY_EN
         chk("busy bit", dout, (i == 8) ? 1'b1 : 1'(8'hB6 >> (7 - i)));
`else
         chk("busy bit", dout, 1'(8'hB6 >> (7 - i)));
`endif
         tick();
      end
      chk("busy vld_end", dout_valid, 1'b0);
      tick();
      chk("busy no_dup", dout_valid, 1'b0);
      chk("busy cnt", word_cnt, 16'd1);

      // Asynchronous reset at bit 4 of 0xFF
      do_reset();
      in_data  = 8'hFF;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("arst pre_vld", dout_valid, 1'b1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst dout", dout, 1'b0);
      chk("arst vld", dout_valid, 1'b0);
      chk("arst busy", busy, 1'b0);
      tick();
      rstn = 1'b1;
      chk("arst ready", in_ready, 1'b1);
      chk("arst cnt", word_cnt, 16'd0);
      tick();
      tick();
      chk("arst idle_vld", dout_valid, 1'b0);
      chk("arst idle_busy", busy, 1'b0);

`ifdef SERIALIZER_PARITY_EN
      // Parity bit follows the payload
      do_reset();
      send("par07", 8'h07, {8'h07, 1'b1});
      send("par03", 8'h03, {8'h03, 1'b0});
      chk("par cnt", word_cnt, 16'd2);
`endif

      // Narrow counter wraps
      do_reset();
      for (int w = 0; w < 5; w++) begin
         send("wrap", 8'hA5, {8'hA5, 1'b0});
         chk("wrap cnt2", word_cnt2, exp_w2[w]);
         chk("wrap cnt16", word_cnt, 16'(w + 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per input word (2..32).
REQ-002 Parameter CNT_W, default 16, width of the completed-word counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 in_data  input  WIDTH  parallel word to serialize.
REQ-006 in_valid  input  1  in_data holds a word to be taken.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  1  serial bit stream, MSB first; drives the 1011 sequence detector's din.
REQ-009 dout_valid  output  1  dout carries a payload bit this cycle.
REQ-010 busy  output  1  a word is in flight (state != IDLE).
REQ-011 word_cnt  output  CNT_W  count of completely emitted words.

Function
REQ-012 The FSM shall have states IDLE, SHIFT, and PARITY (PARITY only when REQ-027 applies).
REQ-013 A word shall be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready shall be combinational: 1 in IDLE, 1 in the last payload cycle of SHIFT when parity is disabled, 1 in PARITY, otherwise 0.
REQ-015 On acceptance, the FSM shall load the shift register and bit counter and enter SHIFT.
REQ-016 In the cycle after acceptance, dout shall be in_data[WIDTH-1] and dout_valid shall be 1.
REQ-017 The remaining bits shall follow MSB to LSB, one per cycle, with no gaps.
REQ-018 dout_valid shall be high for exactly WIDTH cycles per word, or WIDTH+1 with parity.
REQ-019 dout and dout_valid shall be registered outputs.
REQ-020 When dout_valid is 0, dout shall be 0.
REQ-021 After the final bit, the FSM shall return to IDLE, or re-enter SHIFT if a new word is accepted in that same cycle, giving a gapless stream.
REQ-022 Back-to-back words shall produce a continuous dout_valid with no idle cycle between them.
REQ-023 word_cnt shall increment by 1 in the cycle the final bit of a word is emitted, and shall wrap from all-ones to 0.
REQ-024 in_data and in_valid shall be ignored while in_ready is 0; no word shall be lost or duplicated.

Reset
REQ-025 While rstn is 0, the block shall asynchronously clear: state IDLE, dout 0, dout_valid 0, busy 0, word_cnt 0, shift register 0, bit counter 0.
REQ-026 Reset asserted mid-word shall abandon the word with no further dout_valid; the first edge after release shall behave as IDLE.

Configuration
REQ-027 With SERIALIZER_PARITY_EN defined, each word shall be followed by one PARITY cycle with dout equal to the even-parity bit (XOR of all WIDTH bits) and dout_valid 1.
REQ-028 With SERIALIZER_PARITY_EN defined, word_cnt shall increment on the parity cycle.
REQ-029 Without SERIALIZER_PARITY_EN, the PARITY state and its logic shall not exist, and words shall be WIDTH bits long.

Structure
REQ-030 A shared package serializer_pkg shall hold the state enum typedef (IDLE, SHIFT, PARITY; 2-bit encoding) and a parity-bit helper function.
REQ-031 The completed-word counter shall be a separate sub-module, wrap_counter, parameterized by CNT_W, with an async active-low reset and an increment enable.

Verification
REQ-032 Reset, then in_data=8'hB6 with one valid cycle -> dout=1,0,1,1,0,1,1,0 on the next 8 cycles; dout_valid high for 8 cycles; word_cnt=1.
REQ-033 Hold in_valid=1 with 8'hB0 then 8'h0B -> 16 contiguous dout_valid cycles; the stream contains "1011", so the downstream detector pulses; word_cnt=2.
REQ-034 in_valid pulsed while busy, before the last bit -> in_ready=0; the word is not taken; the stream is unchanged.
REQ-035 rstn driven low at bit 4 of 8'hFF -> dout and dout_valid go to 0 immediately without waiting for clk; after release the block is IDLE with word_cnt=0.
REQ-036 With SERIALIZER_PARITY_EN and 8'h07 -> 9 valid bits 0,0,0,0,0,1,1,1,1 (parity=1); with 8'h03 the parity bit is 0.
REQ-037 With CNT_W=2, send 5 words -> word_cnt reads 1,2,3,0,1.
